// File: rtl/spi_cfg_sequencer_if.sv
// Request handshake, status and SPI pins of the config-register write sequencer.
interface spi_cfg_sequencer_if;
   logic       req_valid;
   logic       req_ready;
   logic [6:0] req_addr;
   logic [7:0] req_data;
   logic       busy;
   logic       done;
   logic       err;
   logic       spi_cs_n;
   logic       spi_sclk;
   logic       spi_sdi;

   modport master (
      output req_valid, req_addr, req_data,
      input  req_ready, busy, done, err, spi_cs_n, spi_sclk, spi_sdi
   );

   modport slave (
      input  req_valid, req_addr, req_data,
      output req_ready, busy, done, err, spi_cs_n, spi_sclk, spi_sdi
   );
endinterface

// File: rtl/spi_cfg_sequencer.sv
// SPI master turning register-write requests into 16-bit {1, addr, data} frames, MSB first,
// with the CS setup/hold, SCLK phase and inter-frame gap timing the config slave relies on.
module spi_cfg_sequencer #(
   parameter int unsigned CLK_DIV    = 4,
   parameter int unsigned CS_SETUP   = 4,
   parameter int unsigned CS_HOLD    = 4,
   parameter int unsigned GAP_CYCLES = 8,
   parameter int unsigned NUM_REGS   = 5
) (
   input logic                clk,
   input logic                rst_n,
   spi_cfg_sequencer_if.slave bus
);

   localparam int unsigned CntW = 16;

   typedef enum logic [2:0] {
      StIdle,
      StSetup,
      StSclkHi,
      StSclkLo,
      StHold,
      StGap
   } state_e;

   state_e          state_q;
   logic [CntW-1:0] cnt_q;
   logic [4:0]      bit_cnt_q;
   logic [15:0]     shift_q;
   logic            ready_q;
   logic            busy_q;
   logic            done_q;
   logic            err_q;
   logic            cs_n_q;
   logic            sclk_q;
   logic            sdi_q;

   assign bus.req_ready = ready_q;
   assign bus.busy      = busy_q;
   assign bus.done      = done_q;
   assign bus.err       = err_q;
   assign bus.spi_cs_n  = cs_n_q;
   assign bus.spi_sclk  = sclk_q;
   assign bus.spi_sdi   = sdi_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= StIdle;
         cnt_q     <= '0;
         bit_cnt_q <= '0;
         shift_q   <= '0;
         ready_q   <= 1'b1;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         err_q     <= 1'b0;
         cs_n_q    <= 1'b1;
         sclk_q    <= 1'b0;
         sdi_q     <= 1'b0;
      end else begin
         done_q <= 1'b0;
         err_q  <= 1'b0;
         unique case (state_q)
            StIdle: begin
               if (bus.req_valid && ready_q) begin
                  // Out-of-range addresses are refused without touching the SPI pins.
                  if (32'(bus.req_addr) >= NUM_REGS) begin
                     err_q <= 1'b1;
                  end else begin
                     shift_q   <= {1'b1, bus.req_addr, bus.req_data};
                     sdi_q     <= 1'b1;
                     bit_cnt_q <= '0;
                     cnt_q     <= '0;
                     cs_n_q    <= 1'b0;
                     sclk_q    <= 1'b0;
                     ready_q   <= 1'b0;
                     busy_q    <= 1'b1;
                     state_q   <= StSetup;
                  end
               end
            end
            StSetup: begin
               if (cnt_q == CntW'(CS_SETUP - 1)) begin
                  cnt_q   <= '0;
                  sclk_q  <= 1'b1;
                  state_q <= StSclkHi;
               end else begin
                  cnt_q <= cnt_q + 16'd1;
               end
            end
            StSclkHi: begin
               if (cnt_q == CntW'(CLK_DIV - 1)) begin
                  cnt_q   <= '0;
                  sclk_q  <= 1'b0;
                  state_q <= StSclkLo;
               end else begin
                  cnt_q <= cnt_q + 16'd1;
               end
            end
            StSclkLo: begin
               // sdi only moves at the end of the low phase, well after the slave's sample.
               if (cnt_q == CntW'(CLK_DIV - 1)) begin
                  cnt_q     <= '0;
                  bit_cnt_q <= bit_cnt_q + 5'd1;
                  if (bit_cnt_q == 5'd15) begin
                     state_q <= StHold;
                  end else begin
                     shift_q <= {shift_q[14:0], 1'b0};
                     sdi_q   <= shift_q[14];
                     sclk_q  <= 1'b1;
                     state_q <= StSclkHi;
                  end
               end else begin
                  cnt_q <= cnt_q + 16'd1;
               end
            end
            StHold: begin
               if (cnt_q == CntW'(CS_HOLD - 1)) begin
                  cnt_q   <= '0;
                  cs_n_q  <= 1'b1;
                  sdi_q   <= 1'b0;
                  state_q <= StGap;
               end else begin
                  cnt_q <= cnt_q + 16'd1;
               end
            end
            StGap: begin
               if (cnt_q == CntW'(GAP_CYCLES - 1)) begin
                  cnt_q   <= '0;
                  busy_q  <= 1'b0;
                  ready_q <= 1'b1;
                  state_q <= StIdle;
               end else begin
                  cnt_q <= cnt_q + 16'd1;
                  if (cnt_q == CntW'(GAP_CYCLES - 2)) done_q <= 1'b1;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_spi_cfg_sequencer.sv
// Directed bench: two sequencers (CLK_DIV 4 and 6) feeding a behavioural config-register slave.
module tb_spi_cfg_sequencer;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst4;
   logic rst6;
   bit   sel = 1'b0;

   spi_cfg_sequencer_if b4 ();
   spi_cfg_sequencer_if b6 ();

   spi_cfg_sequencer u_dut4 (
      .clk   (clk),
      .rst_n (rst4),
      .bus   (b4)
   );

   spi_cfg_sequencer #(
      .CLK_DIV (6)
   ) u_dut6 (
      .clk   (clk),
      .rst_n (rst6),
      .bus   (b6)
   );

   int n_tests = 0;
   int n_fail  = 0;

   // Behavioural slave: samples sdi on sclk falls, commits a full write frame on cs_n rise.
   logic        cs;
   logic        sclk;
   logic        sdi;
   assign cs   = b4.spi_cs_n & b6.spi_cs_n;
   assign sclk = b4.spi_sclk | b6.spi_sclk;
   assign sdi  = sel ? b6.spi_sdi : b4.spi_sdi;

   logic        cs_p       = 1'b1;
   logic        sclk_p     = 1'b0;
   logic [15:0] sr_in      = '0;
   logic [15:0] last_frame = '0;
   int bits = 0, rises = 0, frames = 0, sclk_tog = 0;
   int lo_run = 0, lo_len = 0, hi_run = 0, gap_len = 0, ph_run = 0, ph_len = 0;
   logic [7:0] regs [0:4] = '{default: 8'h00};

   always @(posedge clk) begin
      cs_p   <= cs;
      sclk_p <= sclk;
      if (sclk != sclk_p) sclk_tog <= sclk_tog + 1;
      if (!cs) begin
         lo_run <= lo_run + 1;
         if (cs_p) begin
            gap_len <= hi_run;
            hi_run  <= 0;
            bits    <= 0;
            rises   <= 0;
            frames  <= frames + 1;
         end
         if (sclk && !sclk_p) rises <= rises + 1;
         if (!sclk && sclk_p) begin
            sr_in  <= {sr_in[14:0], sdi};
            bits   <= bits + 1;
            ph_len <= ph_run;
         end
         ph_run <= sclk ? ph_run + 1 : 0;
      end else begin
         hi_run <= hi_run + 1;
         if (!cs_p) begin
            lo_len     <= lo_run;
            lo_run     <= 0;
            last_frame <= sr_in;
            if (bits == 16 && sr_in[15] && sr_in[14:8] < 7'd5) regs[sr_in[10:8]] <= sr_in[7:0];
         end
      end
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Wait (bounded) for req_ready and let the next edge take the request; valid stays as is.
   task automatic accept(input bit u6);
      bit ok = 1'b0;
      for (int i = 0; i < 400 && !ok; i++) begin
         ok = u6 ? b6.req_ready : b4.req_ready;
         tick();
      end
      check("accept", 64'(ok), 64'd1);
   endtask

   task automatic send(input bit u6, input logic [6:0] a, input logic [7:0] d);
      if (u6) begin
         b6.req_valid = 1'b1; b6.req_addr = a; b6.req_data = d;
      end else begin
         b4.req_valid = 1'b1; b4.req_addr = a; b4.req_data = d;
      end
      accept(u6);
      b4.req_valid = 1'b0;
      b6.req_valid = 1'b0;
   endtask

   // Called in the first cycle after accept; n is the 1-based cycle in which done is seen.
   task automatic wait_done(input bit u6, output int n);
      n = 1;
      while (!(u6 ? b6.done : b4.done) && n < 400) begin
         tick();
         n++;
      end
   endtask

   function automatic logic [39:0] reg_vec();
      return {regs[0], regs[1], regs[2], regs[3], regs[4]};
   endfunction

   initial begin
      int n, fr, tg;
      rst4 = 1'b0;
      rst6 = 1'b0;
      b4.req_valid = 1'b0; b4.req_addr = '0; b4.req_data = '0;
      b6.req_valid = 1'b0; b6.req_addr = '0; b6.req_data = '0;
      repeat (3) @(posedge clk);
      #1;
      check("reset_outs4", {b4.req_ready, b4.busy, b4.done, b4.err, b4.spi_cs_n, b4.spi_sclk,
                            b4.spi_sdi}, 7'b1000100);
      check("reset_outs6", {b6.req_ready, b6.busy, b6.done, b6.err, b6.spi_cs_n, b6.spi_sclk,
                            b6.spi_sdi}, 7'b1000100);
      rst4 = 1'b1;
      rst6 = 1'b1;
      tick();
      tick();

      // 1: addr 0 <- 0xA5
      send(0, 7'd0, 8'hA5);
      check("t1_busy", {b4.req_ready, b4.busy, b4.spi_cs_n, b4.spi_sdi}, 4'b0101);
      wait_done(0, n);
      check("t1_frame", last_frame, 16'h80A5);
      check("t1_rises", rises, 16);
      check("t1_reg0", regs[0], 8'hA5);
      tick();
      check("t1_idle", {b4.req_ready, b4.busy, b4.done}, 3'b100);

      // 2: addr 4 <- 0x3C, frame timing
      send(0, 7'd4, 8'h3C);
      wait_done(0, n);
      check("t2_done_lat", n, 144);
      check("t2_done_flags", {b4.busy, b4.done, b4.err}, 3'b110);
      check("t2_cs_low", lo_len, 136);
      check("t2_regs", reg_vec(), {8'hA5, 8'h00, 8'h00, 8'h00, 8'h3C});
      tick();

      // 3: addr 5 is out of range
      fr = frames;
      tg = sclk_tog;
      send(0, 7'd5, 8'hFF);
      check("t3_err", {b4.err, b4.req_ready, b4.busy, b4.done}, 4'b1100);
      tick();
      check("t3_err_pulse", b4.err, 1'b0);
      repeat (20) tick();
      check("t3_no_frame", frames, fr);
      check("t3_no_sclk", sclk_tog, tg);
      check("t3_regs", reg_vec(), {8'hA5, 8'h00, 8'h00, 8'h00, 8'h3C});

      // 4: back-to-back with req_valid held; payload changes after the first accept
      b4.req_valid = 1'b1; b4.req_addr = 7'd1; b4.req_data = 8'h11;
      accept(0);
      b4.req_addr = 7'd2; b4.req_data = 8'h22;
      accept(0);
      b4.req_valid = 1'b0;
      wait_done(0, n);
      check("t4_gap", 64'(gap_len >= 8), 64'd1);
      check("t4_regs", reg_vec(), {8'hA5, 8'h11, 8'h22, 8'h00, 8'h3C});
      tick();

      // 5: reset mid-frame after 7 sclk falls
      send(0, 7'd2, 8'h77);
      for (int i = 0; i < 300 && bits != 7; i++) tick();
      check("t5_reach7", bits, 7);
      #2;
      rst4 = 1'b0;
      #1;
      check("t5_async", {b4.req_ready, b4.busy, b4.done, b4.err, b4.spi_cs_n, b4.spi_sclk,
                         b4.spi_sdi}, 7'b1000100);
      tick();
      rst4 = 1'b1;
      repeat (4) tick();
      check("t5_regs", reg_vec(), {8'hA5, 8'h11, 8'h22, 8'h00, 8'h3C});
      send(0, 7'd3, 8'h5A);
      wait_done(0, n);
      check("t5_reg3", regs[3], 8'h5A);
      tick();

      // 6: CLK_DIV = 6 instance
      sel = 1'b1;
      send(1, 7'd1, 8'hC3);
      wait_done(1, n);
      check("t6_done_lat", n, 208);
      check("t6_cs_low", lo_len, 200);
      check("t6_phase", ph_len, 6);
      check("t6_rises", rises, 16);
      check("t6_regs", reg_vec(), {8'hA5, 8'hC3, 8'h22, 8'h5A, 8'h3C});
      tick();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
